mdio_master: RTL and testbench

MDIO_MASTER -- requirements
Module: mdio_master

---
 rtl/mdio_master.sv | 115 +++++++++++
 tb/tb_mdio_master.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// mdio_master: Clause 22 MDIO frame master generating MDC and driving/sampling MDIO
module mdio_master #(
  parameter int CLK_DIV     = 25,
  parameter int PREAMBLE_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, TA, DATA} state_t;
  localparam logic [8:0] PH_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] PH_RISE = 9'(CLK_DIV);
  state_t state_q, state_d, nxt;
  logic [8:0] ph_q, ph_d;
  logic [4:0] cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;
  logic [15:0] rd_q, rd_d, rsp_data_q, rsp_data_d;
  logic wr_q, wr_d, mdc_q, mdc_d, mdo_q, mdo_d, oe_q, oe_d, rsp_valid_q, rsp_valid_d, last;
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign mdc       = mdc_q;
  assign mdio_o    = mdo_q;
  assign mdio_oe   = oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign last = cnt_q == (state_q == PREAMBLE ? 5'd31 : state_q == HEADER ? 5'd13 : state_q == TA ? 5'd1 : 5'd16);
  assign nxt  = state_q == PREAMBLE ? HEADER : state_q == HEADER ? TA : DATA;
  // State, counters and all outputs are registered; rst clears everything immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ph_q        <= '0;
      cnt_q       <= '0;
      sh_q        <= '0;
      rd_q        <= '0;
      wr_q        <= 1'b0;
      mdc_q       <= 1'b0;
      mdo_q       <= 1'b0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      mdc_q       <= mdc_d;
      mdo_q       <= mdo_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end
  // Phase 0 of each bit period drops MDC and launches the next bit (or ends the frame);
  // phase CLK_DIV raises MDC and samples read data. cnt_q indexes the next bit to launch.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    mdc_d       = mdc_q;
    mdo_d       = mdo_q;
    oe_d        = oe_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    if (state_q == IDLE) begin
      ph_d  = '0;
      cnt_d = '0;
      if (cmd_valid) begin
        state_d = PREAMBLE_EN != 0 ? PREAMBLE : HEADER;
        wr_d    = cmd_write;
        sh_d    = {2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy_addr, cmd_reg_addr,
                   cmd_write ? 2'b10 : 2'b00, cmd_write ? cmd_wdata : 16'h0};
      end
    end else begin
      ph_d = ph_q == PH_LAST ? 9'd0 : ph_q + 9'd1;
      if (ph_q == PH_RISE) begin
        mdc_d = 1'b1;
        if (state_q == DATA && cnt_q != 5'd0) rd_d = {rd_q[14:0], mdio_i};
      end
      if (ph_q == 9'd0) begin
        mdc_d = 1'b0;
        if (state_q == DATA && cnt_q == 5'd16) begin
          state_d     = IDLE;
          mdo_d       = 1'b0;
          oe_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = wr_q ? rsp_data_q : rd_q;
        end else begin
          mdo_d   = state_q == PREAMBLE ? 1'b1 : sh_q[31];
          oe_d    = wr_q || state_q == PREAMBLE || state_q == HEADER;
          sh_d    = state_q == PREAMBLE ? sh_q : {sh_q[30:0], 1'b0};
          cnt_d   = last ? 5'd0 : cnt_q + 5'd1;
          state_d = last ? nxt : state_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed checks of frame content, timing, back-to-back, reset abort and MDC phases
module tb_mdio_master;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [4:0] cmd_phy_addr = '0, cmd_reg_addr = '0, c_reg = '0;
  logic [15:0] cmd_wdata = '0, phy_data = '0;
  logic c_valid = 1'b0, mdio_i0 = 1'b1;
  logic [2:0] ready_w, rsp_valid_w, busy_w, mdc_w, mdo_w, oe_w;
  logic [15:0] rsp_data_w [3];
  int checks = 0, failures = 0, r = 0;

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(2), .PREAMBLE_EN(1)) u0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_w[0]), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_w[0]), .rsp_data(rsp_data_w[0]), .busy(busy_w[0]), .mdc(mdc_w[0]),
    .mdio_o(mdo_w[0]), .mdio_oe(oe_w[0]), .mdio_i(mdio_i0));
  mdio_master #(.CLK_DIV(3), .PREAMBLE_EN(0)) u1 (
    .clk(clk), .rst(rst), .cmd_valid(c_valid), .cmd_ready(ready_w[1]), .cmd_write(1'b0),
    .cmd_phy_addr(5'd0), .cmd_reg_addr(c_reg), .cmd_wdata(16'h0),
    .rsp_valid(rsp_valid_w[1]), .rsp_data(rsp_data_w[1]), .busy(busy_w[1]), .mdc(mdc_w[1]),
    .mdio_o(mdo_w[1]), .mdio_oe(oe_w[1]), .mdio_i(1'b1));
  mdio_master #(.CLK_DIV(25), .PREAMBLE_EN(0)) u2 (
    .clk(clk), .rst(rst), .cmd_valid(c_valid), .cmd_ready(ready_w[2]), .cmd_write(1'b0),
    .cmd_phy_addr(5'd0), .cmd_reg_addr(c_reg), .cmd_wdata(16'h0),
    .rsp_valid(rsp_valid_w[2]), .rsp_data(rsp_data_w[2]), .busy(busy_w[2]), .mdc(mdc_w[2]),
    .mdio_o(mdo_w[2]), .mdio_oe(oe_w[2]), .mdio_i(1'b1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // PHY model for u0: r counts MDC rises, so after a fall bit r of the frame is in progress
  always @(posedge mdc_w[0]) r = r + 1;
  always @(negedge mdc_w[0]) mdio_i0 = (r >= 48 && r <= 63) ? phy_data[63 - r] : 1'b1;

  // MDC phase widths and MDIO stability while MDC is high, per instance
  for (genvar g = 0; g < 3; g++) begin : mon
    localparam int D = g == 0 ? 2 : g == 1 ? 3 : 25;
    int run = 0;
    logic pm = 1'b0, pmo = 1'b0, sf = 1'b0;
    always @(negedge clk) begin
      if (rst) begin
        run = 0;
        sf = 1'b0;
      end else begin
        if (mdc_w[g] && pm) chk("mdio_stable_while_mdc_high", mdo_w[g], pmo);
        if (mdc_w[g] != pm) begin
          if (pm) chk("mdc_high_phase", run, D);
          else if (sf) chk("mdc_low_phase", run, D);
          if (pm) sf = busy_w[g];
          run = 1;
        end else run++;
        if (!busy_w[g]) sf = 1'b0;
      end
      pm = mdc_w[g];
      pmo = mdo_w[g];
    end
  end

  task automatic issue(input logic w, input logic [4:0] p, input logic [4:0] a, input logic [15:0] d);
    cmd_write = w;
    cmd_phy_addr = p;
    cmd_reg_addr = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    r = 0;
    @(posedge clk); #1;
    chk("accept_busy", busy_w[0], 1);
  endtask

  task automatic collect(input bit pulse, output int lat, output int fr,
                         output logic [63:0] st, output logic [63:0] oe);
    logic pm;
    pm = mdc_w[0];
    lat = -1;
    fr = -1;
    st = '0;
    oe = '0;
    for (int n = 1; n <= 400 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (mdc_w[0] && !pm) begin
        st = {st[62:0], mdo_w[0]};
        oe = {oe[62:0], oe_w[0]};
        if (fr < 0) fr = n;
      end
      pm = mdc_w[0];
      if (rsp_valid_w[0]) lat = n;
      if (pulse) cmd_valid = (n >= 250) || (n % 10 >= 5);
    end
  endtask

  initial begin
    int lat, fr, n, l1, l2;
    logic [63:0] st, oe;
    logic seen;
    @(posedge clk); #1;
    chk("rst_mdc", mdc_w[0], 0);
    chk("rst_mdio_o", mdo_w[0], 0);
    chk("rst_mdio_oe", oe_w[0], 0);
    chk("rst_rsp_valid", rsp_valid_w[0], 0);
    chk("rst_rsp_data", rsp_data_w[0], 0);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_ready", ready_w[0], 1);
    rst = 1'b0;
    @(posedge clk); #1;
    issue(1'b1, 5'd1, 5'd0, 16'h1140);
    cmd_valid = 1'b0;
    collect(1'b0, lat, fr, st, oe);
    chk("wr_lat", lat, 257);
    chk("wr_first_rise", fr, 3);
    chk("wr_stream", st, {32'hFFFF_FFFF, 16'h5082, 16'h1140});
    chk("wr_oe", oe, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wr_ready_at_rsp", ready_w[0], 1);
    chk("wr_busy_at_rsp", busy_w[0], 0);
    chk("wr_rsp_data_kept", rsp_data_w[0], 16'h0);
    @(posedge clk); #1;
    chk("wr_rsp_one_cycle", rsp_valid_w[0], 0);
    phy_data = 16'h0141;
    issue(1'b0, 5'd3, 5'd2, 16'hFFFF);
    cmd_valid = 1'b0;
    collect(1'b0, lat, fr, st, oe);
    chk("rd_lat", lat, 257);
    chk("rd_stream", st, {32'hFFFF_FFFF, 16'h6188, 16'h0});
    chk("rd_oe", oe, 64'hFFFF_FFFF_FFFC_0000);
    chk("rd_data", rsp_data_w[0], 16'h0141);
    issue(1'b1, 5'd2, 5'd5, 16'h1234);
    cmd_phy_addr = 5'd7;
    cmd_reg_addr = 5'd31;
    cmd_wdata = 16'hA5C3;
    collect(1'b1, lat, fr, st, oe);
    chk("b2b1_lat", lat, 257);
    chk("b2b1_stream", st, {32'hFFFF_FFFF, 16'h5116, 16'h1234});
    @(posedge clk); #1;
    chk("b2b2_accept", busy_w[0], 1);
    cmd_valid = 1'b0;
    collect(1'b0, lat, fr, st, oe);
    chk("b2b2_lat", lat, 257);
    chk("b2b2_first_rise", fr, 3);
    chk("b2b2_stream", st, {32'hFFFF_FFFF, 16'h53FE, 16'hA5C3});
    chk("b2b_rsp_data_kept", rsp_data_w[0], 16'h0141);
    issue(1'b0, 5'd3, 5'd2, 16'h0);
    cmd_valid = 1'b0;
    n = 0;
    while (n < 400 && !(r == 41 && mdc_w[0])) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_reached_bit40", n < 400, 1);
    rst = 1'b1;
    #1;
    chk("abort_mdc", mdc_w[0], 0);
    chk("abort_oe", oe_w[0], 0);
    chk("abort_busy", busy_w[0], 0);
    chk("abort_ready", ready_w[0], 1);
    chk("abort_rsp_data", rsp_data_w[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      seen |= rsp_valid_w[0];
    end
    chk("abort_no_rsp", seen, 0);
    phy_data = 16'h8001;
    issue(1'b0, 5'd3, 5'd2, 16'h0);
    cmd_valid = 1'b0;
    collect(1'b0, lat, fr, st, oe);
    chk("post_rst_lat", lat, 257);
    chk("post_rst_stream", st, {32'hFFFF_FFFF, 16'h6188, 16'h0});
    chk("post_rst_data", rsp_data_w[0], 16'h8001);
    c_reg = 5'd1;
    c_valid = 1'b1;
    @(posedge clk); #1;
    c_valid = 1'b0;
    l1 = -1;
    l2 = -1;
    for (int k = 1; k <= 1700 && (l1 < 0 || l2 < 0); k++) begin
      @(posedge clk); #1;
      if (rsp_valid_w[1] && l1 < 0) l1 = k;
      if (rsp_valid_w[2] && l2 < 0) l2 = k;
    end
    chk("nopre_div3_lat", l1, 193);
    chk("nopre_div25_lat", l2, 1601);
    chk("nopre_div3_data", rsp_data_w[1], 16'hFFFF);
    chk("nopre_div25_data", rsp_data_w[2], 16'hFFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
